// File: rtl/sr_button_conditioner_if.sv
// Button inputs and latch command outputs of the SR button conditioner.
// slave is the conditioner side and master is the driver/observer side.
interface sr_button_conditioner_if;
  logic btn_set;
  logic btn_reset;
  logic s;
  logic r;
  logic enable;
  logic conflict;
  logic busy;

  modport slave (
    input  btn_set, btn_reset,
    output s, r, enable, conflict, busy
  );

  modport master (
    output btn_set, btn_reset,
    input  s, r, enable, conflict, busy
  );
endinterface

// File: rtl/sr_button_conditioner.sv
// Conditions two bouncy push buttons into clean one-cycle set/reset commands
// for a gated SR latch. The path is: sync, debounce, rising-edge, arbitrate, holdoff.
//
// state      | meaning
// ST_IDLE    | waiting for a request
// ST_PULSE_S | s=1 and enable=1 for one cycle
// ST_PULSE_R | r=1 and enable=1 for one cycle
// ST_CONFLICT| set and reset rose together; conflict=1 for one cycle
// ST_HOLDOFF | rate-limit window; requests are dropped
module sr_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sr_button_conditioner_if.slave bus
);

  localparam logic [7:0] DB_TC       = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HO_LOAD     = 8'(HOLDOFF_CYCLES - 1);
  localparam bit         HAS_HOLDOFF = (HOLDOFF_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE_S,
    ST_PULSE_R,
    ST_CONFLICT,
    ST_HOLDOFF
  } state_t;

  // Bit 0 carries the set button and bit 1 carries the reset button.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_deb;
  logic [1:0] r_deb_prev;
  logic [7:0] r_cnt [2];
  logic [1:0] w_req;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb      <= '0;
      r_deb_prev <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= {bus.btn_reset, bus.btn_set};
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      // Any sample agreeing with the debounced level restarts the count.
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_TC) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_req = r_deb & ~r_deb_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req == 2'b11)  w_state_nxt = ST_CONFLICT;
        else if (w_req[0])   w_state_nxt = ST_PULSE_S;
        else if (w_req[1])   w_state_nxt = ST_PULSE_R;
      end
      ST_PULSE_S, ST_PULSE_R, ST_CONFLICT: begin
        if (HAS_HOLDOFF) begin
          w_state_nxt    = ST_HOLDOFF;
          w_hold_cnt_nxt = HO_LOAD;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == 8'd0) w_state_nxt    = ST_IDLE;
        else                    w_hold_cnt_nxt = r_hold_cnt - 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state register, so s and r are exclusive by construction.
  assign bus.s        = (r_state == ST_PULSE_S);
  assign bus.r        = (r_state == ST_PULSE_R);
  assign bus.enable   = (r_state == ST_PULSE_S) || (r_state == ST_PULSE_R);
  assign bus.conflict = (r_state == ST_CONFLICT);
  assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Scoreboard bench: stimulus pushes the expected command events, and a negedge monitor
// pops them and checks the kind, the cycle, the busy window length and the output invariants.
module tb_sr_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_button_conditioner_if bus_a ();
  sr_button_conditioner_if bus_b ();

  sr_button_conditioner #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(3)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  sr_button_conditioner #(.DEBOUNCE_CYCLES(1), .HOLDOFF_CYCLES(0)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  // kind: 0 = s pulse, 1 = r pulse, 2 = conflict pulse
  typedef struct {
    int kind;
    int cyc;
    int busy_len;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   run[2]      = '{0, 0};
  int   exp_busy[2] = '{-1, -1};

  task automatic push(input int id, input int kind, input int c, input int bl);
    exp_t e;
    e.kind = kind; e.cyc = c; e.busy_len = bl;
    if (id == 0) q_a.push_back(e);
    else         q_b.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input logic s, input logic r, input logic en,
                     input logic cf, input logic busy);
    exp_t e;
    int   kind;
    int   have;
    tests++;
    if (s === 1'b1 && r === 1'b1) begin
      fails++;
      $display("FAIL dut%0d s_r_exclusive: s=%b r=%b expected not both 1 (cycle %0d)", id, s, r, cyc);
    end
    tests++;
    if (en !== (s | r)) begin
      fails++;
      $display("FAIL dut%0d enable_eq_s_or_r: enable=%b expected %b (cycle %0d)", id, en, s | r, cyc);
    end
    if (s === 1'b1 || r === 1'b1 || cf === 1'b1) begin
      kind = (s === 1'b1) ? 0 : ((r === 1'b1) ? 1 : 2);
      have = (id == 0) ? q_a.size() : q_b.size();
      tests++;
      if (have == 0) begin
        fails++;
        exp_busy[id] = -1;
        $display("FAIL dut%0d unexpected_event: kind %0d at cycle %0d, expected none", id, kind, cyc);
      end else begin
        if (id == 0) e = q_a.pop_front();
        else         e = q_b.pop_front();
        exp_busy[id] = e.busy_len;
        if (e.kind != kind || e.cyc != cyc) begin
          fails++;
          $display("FAIL dut%0d event: kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                   id, kind, cyc, e.kind, e.cyc);
        end
      end
    end
    if (busy === 1'b1) begin
      run[id]++;
    end else if (run[id] > 0) begin
      tests++;
      if (run[id] != exp_busy[id]) begin
        fails++;
        $display("FAIL dut%0d busy_len: got %0d expected %0d (ending cycle %0d)",
                 id, run[id], exp_busy[id], cyc);
      end
      run[id]      = 0;
      exp_busy[id] = -1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.s, bus_a.r, bus_a.enable, bus_a.conflict, bus_a.busy);
    mon(1, bus_b.s, bus_b.r, bus_b.enable, bus_b.conflict, bus_b.busy);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int bounce[4];
    bounce = '{1, 0, 1, 0};
    bus_a.btn_set = 1'b0; bus_a.btn_reset = 1'b0;
    bus_b.btn_set = 1'b0; bus_b.btn_reset = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("reset_a_outputs", {bus_a.s, bus_a.r, bus_a.enable, bus_a.conflict, bus_a.busy}, 0);
    check("reset_b_outputs", {bus_b.s, bus_b.r, bus_b.enable, bus_b.conflict, bus_b.busy}, 0);
    step(3);

    // 1: clean set press, held
    bus_a.btn_set = 1'b1;
    push(0, 0, cyc + 1 + 6, 4);
    step(20);
    check("t1_held_not_busy", bus_a.busy, 0);
    bus_a.btn_set = 1'b0;
    step(10);

    // 2: bouncy reset, then stable hold
    foreach (bounce[i]) begin
      bus_a.btn_reset = bounce[i][0];
      step(1);
    end
    bus_a.btn_reset = 1'b1;
    push(0, 1, cyc + 1 + 6, 4);
    step(20);
    bus_a.btn_reset = 1'b0;
    step(10);

    // 3: simultaneous press
    bus_a.btn_set = 1'b1; bus_a.btn_reset = 1'b1;
    push(0, 2, cyc + 1 + 6, 4);
    step(20);
    check("t3_held_not_busy", bus_a.busy, 0);
    bus_a.btn_set = 1'b0; bus_a.btn_reset = 1'b0;
    step(10);

    // 4: reset edge lands in holdoff and is dropped, then accepted later
    bus_a.btn_set = 1'b1;
    push(0, 0, cyc + 1 + 6, 4);
    step(3);
    bus_a.btn_reset = 1'b1;
    step(5);
    bus_a.btn_set = 1'b0;
    step(15);
    bus_a.btn_reset = 1'b0;
    step(10);
    bus_a.btn_reset = 1'b1;
    push(0, 1, cyc + 1 + 6, 4);
    step(15);
    bus_a.btn_reset = 1'b0;
    step(10);

    // 5: reset during the s pulse with set held
    bus_a.btn_set = 1'b1;
    k = cyc + 1;
    push(0, 0, k + 6, 1);
    step(7);
    check("t5_s_before_rst", bus_a.s, 1);
    rst = 1'b1;
    step(1);
    check("t5_rst_clears", {bus_a.s, bus_a.enable, bus_a.busy}, 0);
    rst = 1'b0;
    push(0, 0, cyc + 1 + 6, 4);
    step(20);
    bus_a.btn_set = 1'b0;
    step(10);

    // 6: no holdoff, single-sample debounce
    bus_b.btn_set = 1'b1;
    push(1, 0, cyc + 1 + 3, 1);
    step(4);
    bus_b.btn_set = 1'b0;
    step(4);
    bus_b.btn_reset = 1'b1;
    push(1, 1, cyc + 1 + 3, 1);
    step(4);
    bus_b.btn_reset = 1'b0;
    step(8);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    check("a_busy_idle_end", run[0], 0);
    check("b_busy_idle_end", run[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_button_conditioner.md
Name: sr_button_conditioner

Overview:
Upstream stage for the gated SR latch. Takes two raw, asynchronous, bouncy push-button inputs (set, reset) and conditions them into clean single-cycle command pulses on s, r and enable. Inputs are synchronised and debounced, then only the rising edges are kept. Simultaneous set/reset requests are arbitrated away so the latch never sees S=R=1. A post-command holdoff window rate-limits commands.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples that must differ from the debounced level before it flips; legal range 1..255
HOLDOFF_CYCLES, 3, idle cycles enforced after each command or conflict before the next request is accepted; legal range 0..255

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
btn_set  input  1  raw set button, asynchronous to clk, may bounce
btn_reset  input  1  raw reset button, asynchronous to clk, may bounce
s  output  1  set command to the latch; one-cycle pulse
r  output  1  reset command to the latch; one-cycle pulse
enable  output  1  latch enable; high exactly in the cycles where s or r is high
conflict  output  1  one-cycle pulse when set and reset requests collide
busy  output  1  high while a command or holdoff is in progress

Behaviour:
- Reset (rst=1 at a posedge):
  - s, r, enable, conflict and busy all clear to 0.
  - Both synchronisers clear to 0; debounced levels clear to 0; debounce counters clear to 0.
  - FSM goes to IDLE.
  - rst overrides everything in the same cycle, including mid-PULSE and mid-HOLDOFF.
- Synchroniser: two-flop chain per button; only the second flop output feeds later logic.
- Debounce, per button:
  - 8-bit counter.
  - When the sync sample equals the debounced level, the counter clears.
  - When it differs, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level flips and the counter clears.
  - Any sample matching the debounced level restarts the count, so glitches shorter than DEBOUNCE_CYCLES samples are rejected.
- Edge detect: a request is debounced & ~debounced_prev (rising edge only). Releasing a button produces no request.
- FSM, state transitions:
  - IDLE: exactly one request -> PULSE, registering s=1 (set) or r=1 (reset) and enable=1.
  - IDLE: both requests in the same cycle -> conflict=1 for one cycle, s=r=enable=0, then HOLDOFF (or IDLE if HOLDOFF_CYCLES=0).
  - PULSE: lasts exactly one cycle; s/r/enable return to 0 on the next edge -> HOLDOFF, or IDLE if HOLDOFF_CYCLES=0.
  - HOLDOFF: lasts exactly HOLDOFF_CYCLES cycles, counted by an 8-bit down-counter -> IDLE.
- Outputs and invariants:
  - busy=1 in PULSE and HOLDOFF, and in the conflict cycle; 0 in IDLE.
  - s and r are never high in the same cycle.
  - enable == s | r in every cycle.
- Dropped requests: requests whose rising edge occurs while busy are discarded, not queued. A button still held after holdoff produces no new command until it is released and pressed again.
- Latency: btn_set goes to 1 clean before posedge k and stays high -> s=1 in the cycle after posedge k+DEBOUNCE_CYCLES+2. With the default DEBOUNCE_CYCLES=4 that is posedge k+6. btn_reset to r follows the same latency.
- Button held through reset: after reset deasserts, the debounced level restarts from 0. A held button therefore produces one command at the normal latency after rst falls.

Test Plan:
1. Reset, then btn_set clean 0->1 before edge 10 and held -> s=1, enable=1 exactly in the cycle after edge 16; r=0 throughout; busy high for 4 cycles (1 pulse + 3 holdoff); then busy=0 and no further pulses while held.
2. btn_reset bounces 1,0,1,0 on alternate cycles, then holds 1 -> no r until the hold has 4 stable samples; single r pulse at the normal latency from the start of the stable hold.
3. btn_set and btn_reset rise clean on the same edge -> conflict=1 for one cycle; s=r=enable=0 throughout; busy high for 4 cycles; no command afterwards while both are held.
4. btn_set press, release after 8 cycles, then btn_reset pressed so its edge lands during HOLDOFF -> one s pulse only, reset request dropped. Repeat with btn_reset pressed after busy falls -> r pulse.
5. rst asserted for 1 cycle during the s pulse with btn_set held -> s=enable=busy=0 on the next edge; exactly one new s pulse DEBOUNCE_CYCLES+2 edges after rst falls.
6. HOLDOFF_CYCLES=0, DEBOUNCE_CYCLES=1: set press, release, reset press at 4-cycle spacing -> s pulse then r pulse; busy high only in pulse cycles; the s=r=1 invariant never violated.
